// File: rtl/packet_uart_tx.sv
// packet_uart_tx
//
// Sends 32-bit packets on an asynchronous serial line as four 8N1 bytes,
// least-significant byte first and each byte LSB first. Each bit lasts
// CLKS_PER_BIT clocks. The bytes of a packet are back to back, with no idle
// bits between them. A one-entry holding register lets the producer queue
// the next packet while the current one is on the wire. A queued packet
// starts with no idle gap after the current one.
//
// Ports
//   clk       system clock; all logic is on the rising edge
//   reset     synchronous, active-high; aborts any packet in flight
//   vld_in    producer has a packet on `packet`
//   packet    packet to send; packet[7:0] goes out first
//   rdy_out   combinational; the block accepts a packet this cycle (!hold_full)
//   tx_out    registered serial line; idles high
//   busy_out  registered; high while any bit of a packet is on the line
//   done_out  registered; one-cycle pulse after the last stop bit of a packet

module packet_uart_tx #(
  parameter int CLKS_PER_BIT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vld_in,
  input  logic [31:0] packet,
  output logic        rdy_out,
  output logic        tx_out,
  output logic        busy_out,
  output logic        done_out
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       shifter_q, shifter_d;
  logic [31:0]       hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic accept;
  logic baud_end;
  logic packet_end;

  assign rdy_out  = !hold_full_q;
  assign tx_out   = tx_q;
  assign busy_out = busy_q;
  assign done_out = done_q;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    shifter_d   = shifter_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;

    accept     = vld_in && !hold_full_q;
    baud_end   = (baud_q == BAUD_LAST);
    packet_end = (state_q == S_STOP) && baud_end && (byte_idx_q == 2'd3);

    // The baud counter free-runs while a packet is on the line. Every bit
    // boundary wraps it to 0, so the next bit starts on the following clock.
    if (state_q != S_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shifter_d  = packet;
          byte_idx_d = 2'd0;
          baud_d     = '0;
          state_d    = S_START;
        end
      end

      S_START: begin
        if (baud_end) begin
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_end) begin
          shifter_d = shifter_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (baud_end) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_START;
          end else begin
            done_d     = 1'b1;
            byte_idx_d = 2'd0;
            if (hold_full_q) begin
              shifter_d   = hold_q;
              hold_full_d = 1'b0;
              state_d     = S_START;
            end else if (accept) begin
              // A packet offered on the very edge that ends the current one
              // goes straight into the shifter. Parking it in the holding
              // register would leave it stranded while the FSM sits in IDLE.
              shifter_d = packet;
              state_d   = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accepts made while a packet is on the line go to the holding register.
    // When the holding register is full, rdy_out is low. A hold-to-shifter
    // move therefore never collides with a new accept.
    if (accept && (state_q != S_IDLE) && !packet_end) begin
      hold_d      = packet;
      hold_full_d = 1'b1;
    end

    // The line and busy outputs are registered. They are derived from the
    // next state, so they change on the same edge as the FSM.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shifter_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= 3'd0;
      byte_idx_q  <= 2'd0;
      shifter_q   <= 32'd0;
      hold_q      <= 32'd0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      shifter_q   <= shifter_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule
